// File: rtl/collision_scheduler.sv
// collision_scheduler: sweeps every lattice cell once per start, reads its
// densities from the distribution BRAM, streams them into the collider and
// writes the collided result back to the same cell address.
// Optional build macro: COLLISION_SCHED_WATCHDOG_EN adds a completion
// watchdog that flags an error and closes the sweep when the collider stalls.
module collision_scheduler #(
  parameter int GRID_W          = 64,
  parameter int GRID_H          = 48,
  parameter int ADDR_W          = 12,
  parameter int RD_LAT          = 2,
  parameter int ISSUE_INTERVAL  = 17,
  parameter int MAX_INFLIGHT    = 4,
  parameter int WATCHDOG_CYCLES = 64
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              rd_en_out,
  output logic [ADDR_W-1:0] rd_addr_out,
  input  logic [71:0]       rd_data_in,
  output logic [71:0]       coll_data_out,
  output logic              coll_valid_out,
  input  logic [71:0]       coll_data_in,
  input  logic              coll_done_in,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [71:0]       wr_data_out,
  output logic [ADDR_W:0]   cells_done_out,
  output logic              error_out
);

  localparam int NUM_CELLS = GRID_W * GRID_H;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CELLS - 1);
  localparam int GAP_W = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(ISSUE_INTERVAL - 1);
  localparam int PTR_W = $clog2(MAX_INFLIGHT);
  localparam logic [PTR_W:0] FIFO_FULL = (PTR_W+1)'(MAX_INFLIGHT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                              state, state_nx;
  logic [ADDR_W-1:0]                   issue_idx;
  logic [GAP_W-1:0]                    gap_cnt;
  logic [MAX_INFLIGHT-1:0][ADDR_W-1:0] fifo_mem;
  logic [PTR_W-1:0]                    wr_ptr, rd_ptr;
  logic [PTR_W:0]                      fifo_cnt;
  logic [RD_LAT:1]                     vld_pipe;
  logic fifo_empty, fifo_full, fault, pop, issue, wd_fire;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL);
  // A completion with nothing outstanding (or while idle) has no address to
  // retire: flag it and drop it.
  assign fault = coll_done_in && ((state == S_IDLE) || fifo_empty);
  assign pop   = coll_done_in && !fault;
  // A retiring completion frees its slot in the same cycle, so a full FIFO
  // can still accept the next issue alongside the pop.
  assign issue = (state == S_ISSUE) && (gap_cnt == '0) && (!fifo_full || pop) && !wd_fire;

`ifdef COLLISION_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  assign wd_fire = !fifo_empty && !coll_done_in && (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1));
  // Count cycles with work outstanding but no completion arriving.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)                                  wd_cnt <= '0;
    else if (fifo_empty || coll_done_in || wd_fire) wd_cnt <= '0;
    else                                          wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_fire = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nx       = state;
    busy_out       = (state == S_ISSUE) || (state == S_DRAIN);
    done_out       = (state == S_DONE);
    rd_en_out      = issue;
    rd_addr_out    = issue ? issue_idx : '0;
    coll_valid_out = vld_pipe[RD_LAT];
    coll_data_out  = vld_pipe[RD_LAT] ? rd_data_in : '0;
    case (state)
      S_IDLE:  if (start_in) state_nx = S_ISSUE;
      S_ISSUE: if (issue && (issue_idx == LAST_IDX)) state_nx = S_DRAIN;
      S_DRAIN: if (fifo_empty) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (wd_fire) state_nx = S_DONE;
  end

  // Sweep bookkeeping: next cell index, issue throttle, completed-cell count.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      issue_idx      <= '0;
      gap_cnt        <= '0;
      cells_done_out <= '0;
    end else if (state == S_IDLE) begin
      if (start_in) begin
        issue_idx      <= '0;
        gap_cnt        <= '0;
        cells_done_out <= '0;
      end
    end else begin
      if (issue) begin
        gap_cnt <= GAP_RELOAD;
        if (issue_idx != LAST_IDX) issue_idx <= issue_idx + 1'b1;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
      if (pop) cells_done_out <= cells_done_out + 1'b1;
    end
  end

  // In-flight address FIFO; the collider is in-order, so the head is always
  // the cell that just completed.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      fifo_mem <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (wd_fire) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (issue) begin
        fifo_mem[wr_ptr] <= issue_idx;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({issue, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Register the write-back one cycle after the completion.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_en_out   <= 1'b0;
      wr_addr_out <= '0;
      wr_data_out <= '0;
    end else begin
      wr_en_out <= pop;
      if (pop) begin
        wr_addr_out <= fifo_mem[rd_ptr];
        wr_data_out <= coll_data_in;
      end
    end
  end

  // Read-enable delay line matching the BRAM read latency.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= issue;
      for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)               error_out <= 1'b0;
    else if (fault || wd_fire) error_out <= 1'b1;
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed bench for collision_scheduler on a 2x2 lattice with a throttled
// issue interval of 3, two in-flight slots and a 20-cycle collider model.
module tb_collision_scheduler;

  localparam int AW   = 4;
  localparam int NC   = 4;
  localparam int CLAT = 20;
  localparam logic [71:0] KEY = {9{8'hA5}};

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          start_in = 1'b0;
  logic          busy_out, done_out, rd_en_out, coll_valid_out, wr_en_out, error_out;
  logic [AW-1:0] rd_addr_out, wr_addr_out;
  logic [71:0]   rd_data_in = '0;
  logic [71:0]   coll_data_out, coll_data_in, wr_data_out;
  logic          coll_done_in;
  logic [AW:0]   cells_done_out;

  collision_scheduler #(
    .GRID_W(2), .GRID_H(2), .ADDR_W(AW), .RD_LAT(2), .ISSUE_INTERVAL(3),
    .MAX_INFLIGHT(2), .WATCHDOG_CYCLES(64)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .busy_out(busy_out), .done_out(done_out),
    .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out), .rd_data_in(rd_data_in),
    .coll_data_out(coll_data_out), .coll_valid_out(coll_valid_out),
    .coll_data_in(coll_data_in), .coll_done_in(coll_done_in),
    .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
    .cells_done_out(cells_done_out), .error_out(error_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [71:0] cell_val(input int a);
    logic [71:0] v;
    for (int b = 0; b < 9; b++) v[b*8 +: 8] = 8'(a * 16 + b);
    return v;
  endfunction

  // BRAM + collider models
  typedef struct { int due; logic [71:0] d; } job_t;
  job_t        jobs[$];
  int          cyc = 0;
  int          comp_seen = 0;
  int          drop_at = -1;
  logic [71:0] r1 = '0;
  logic        model_done = 1'b0;
  logic [71:0] model_data = '0;
  logic        inj_done = 1'b0;
  logic [71:0] inj_data = '0;

  assign coll_done_in = model_done | inj_done;
  assign coll_data_in = inj_done ? inj_data : model_data;

  always @(posedge clk_in) begin
    cyc        <= cyc + 1;
    r1         <= rd_en_out ? cell_val(int'(rd_addr_out)) : '0;
    rd_data_in <= r1;
    model_done <= 1'b0;
    if (jobs.size() > 0 && jobs[0].due == cyc) begin
      if (comp_seen != drop_at) begin
        model_done <= 1'b1;
        model_data <= jobs[0].d ^ KEY;
      end
      comp_seen <= comp_seen + 1;
      void'(jobs.pop_front());
    end
    if (coll_valid_out) jobs.push_back(job_t'{cyc + CLAT - 1, coll_data_out});
  end

  // Event monitor
  int          rd_cyc[$], rd_adr[$], vld_cyc[$], wr_cyc[$], wr_adr[$], done_cyc[$];
  logic [71:0] wr_dat[$];

  always @(negedge clk_in) begin
    if (rd_en_out) begin rd_cyc.push_back(cyc); rd_adr.push_back(int'(rd_addr_out)); end
    if (coll_valid_out) vld_cyc.push_back(cyc);
    if (wr_en_out) begin
      wr_cyc.push_back(cyc); wr_adr.push_back(int'(wr_addr_out)); wr_dat.push_back(wr_data_out);
    end
    if (done_out) done_cyc.push_back(cyc);
  end

  int n_cmp = 0;
  int n_err = 0;
  int exp_rd[4]  = '{0, 3, 22, 25};
  int exp_vld[4] = '{2, 5, 24, 27};
  int exp_wr[4]  = '{23, 26, 45, 48};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    tick(); tick();
    rst_in = 1'b1;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy_out, 0);
    chk({tag, "_done"}, done_out, 0);
    chk({tag, "_rd_en"}, rd_en_out, 0);
    chk({tag, "_rd_addr"}, rd_addr_out, 0);
    chk({tag, "_cvalid"}, coll_valid_out, 0);
    chk({tag, "_cdata"}, coll_data_out, 0);
    chk({tag, "_wr_en"}, wr_en_out, 0);
    chk({tag, "_wr_addr"}, wr_addr_out, 0);
    chk({tag, "_wr_data"}, wr_data_out, 0);
    chk({tag, "_cells"}, cells_done_out, 0);
    chk({tag, "_error"}, error_out, 0);
  endtask

  // Pulse start; leaves the caller in the first ISSUE cycle.
  task automatic pulse_start(input string tag);
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    chk({tag, "_busy_on"}, busy_out, 1);
    chk({tag, "_cells_clr"}, cells_done_out, 0);
  endtask

  task automatic run_sweep(input string tag, input logic exp_err);
    int b_rd, b_vld, b_wr, c0, t;
    logic seen;
    b_rd = rd_cyc.size(); b_vld = vld_cyc.size(); b_wr = wr_cyc.size();
    pulse_start(tag);
    c0 = cyc;
    seen = 1'b0;
    t = 0;
    while (!seen && t < 400) begin
      tick(); t++;
      if (done_out) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_done_cyc"}, cyc - c0, 49);
    chk({tag, "_busy_at_done"}, busy_out, 0);
    chk({tag, "_cells"}, cells_done_out, NC);
    chk({tag, "_error"}, error_out, exp_err);
    chk({tag, "_n_rd"}, rd_cyc.size() - b_rd, NC);
    chk({tag, "_n_vld"}, vld_cyc.size() - b_vld, NC);
    chk({tag, "_n_wr"}, wr_cyc.size() - b_wr, NC);
    if (rd_cyc.size() - b_rd >= NC && vld_cyc.size() - b_vld >= NC && wr_cyc.size() - b_wr >= NC) begin
      for (int i = 0; i < NC; i++) begin
        chk($sformatf("%s_rd_cyc%0d", tag, i), rd_cyc[b_rd+i] - c0, exp_rd[i]);
        chk($sformatf("%s_rd_addr%0d", tag, i), rd_adr[b_rd+i], i);
        chk($sformatf("%s_vld_cyc%0d", tag, i), vld_cyc[b_vld+i] - c0, exp_vld[i]);
        chk($sformatf("%s_wr_cyc%0d", tag, i), wr_cyc[b_wr+i] - c0, exp_wr[i]);
        chk($sformatf("%s_wr_addr%0d", tag, i), wr_adr[b_wr+i], i);
        chk($sformatf("%s_wr_data%0d", tag, i), wr_dat[b_wr+i], cell_val(i) ^ KEY);
      end
    end
    tick();
    chk({tag, "_done_pulse"}, done_out, 0);
  endtask

  initial begin
    int b_wr, b_dn, t, c0;
    logic seen;

    // Reset state
    tick(); tick();
    chk_all_zero("reset");
    rst_in = 1'b1;
    tick();

    // Full sweep: throttled issue, full-FIFO stall with same-cycle push/pop
    run_sweep("sweep1", 1'b0);

    // Completion while idle: flagged, no write
    b_wr = wr_cyc.size();
    inj_data = {9{8'h3C}};
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    chk("idle_done_err", error_out, 1);
    tick(); tick(); tick();
    chk("idle_done_nowr", wr_cyc.size() - b_wr, 0);
    chk("idle_done_cells", cells_done_out, NC);

    // Later sweep still completes; error stays set
    run_sweep("sweep2", 1'b1);

    // Reset in the middle of a sweep with two cells outstanding
    b_wr = wr_cyc.size();
    t = rd_cyc.size();
    pulse_start("midrst");
    tick(); tick(); tick(); tick();
    chk("midrst_issued", rd_cyc.size() - t, 2);
    rst_in = 1'b0;
    #1;
    chk_all_zero("midrst_abort");
    tick();
    chk("midrst_vld_cleared", coll_valid_out, 0);
    tick();
    rst_in = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("midrst_late_err", error_out, 1);
    chk("midrst_late_nowr", wr_cyc.size() - b_wr, 0);
    chk("midrst_busy", busy_out, 0);
    chk("midrst_cells", cells_done_out, 0);

    // Drop one completion
    do_reset();
    chk("drop_err_clr", error_out, 0);
    drop_at = comp_seen;
    b_wr = wr_cyc.size();
    b_dn = done_cyc.size();
    pulse_start("drop");
    c0 = cyc;
`ifdef COLLISION_SCHED_WATCHDOG_EN
    seen = 1'b0;
    t = 0;
    while (!seen && t < 400) begin
      tick(); t++;
      if (done_out) seen = 1'b1;
    end
    chk("wd_done_seen", seen, 1);
    chk("wd_fire_cyc", cyc - c0, 134);
    chk("wd_error", error_out, 1);
    chk("wd_cells", cells_done_out, NC - 1);
    chk("wd_busy", busy_out, 0);
`else
    for (int i = 0; i < 200; i++) tick();
    chk("hang_busy", busy_out, 1);
    chk("hang_no_done", done_cyc.size() - b_dn, 0);
    chk("hang_cells", cells_done_out, NC - 1);
    chk("hang_n_wr", wr_cyc.size() - b_wr, NC - 1);
    chk("hang_error", error_out, 0);
    c0 = cyc - c0;
`endif
    do_reset();
    chk("final_reset_busy", busy_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
